// File: rtl/aes_uart_ctrl.sv
// UART-to-AES bridge: gathers a 16-byte key and a 16-byte plaintext from the RX stream, starts the core, and streams the 16-byte cipher to TX.
// Optional build macro AES_CTRL_KEY_HOLD_EN adds a header state ('K' new key, 'P' reuse the stored key).
module aes_uart_ctrl #(
    parameter int unsigned LATENCY = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic [127:0] aes_key,
    output logic [127:0] aes_plaintext,
    output logic         aes_enable,
    input  logic [127:0] aes_cypher,
    output logic         busy,
    output logic         done,
    output logic         rx_overrun
);

    typedef enum logic [2:0] {
        ST_LOAD_KEY = 3'd0,
        ST_LOAD_PT  = 3'd1,
        ST_START    = 3'd2,
        ST_WAIT     = 3'd3,
        ST_SEND     = 3'd4
`ifdef AES_CTRL_KEY_HOLD_EN
        , ST_HDR    = 3'd5
`endif
    } state_e;

`ifdef AES_CTRL_KEY_HOLD_EN
    localparam state_e ST_HOME = ST_HDR;
`else
    localparam state_e ST_HOME = ST_LOAD_KEY;
`endif

    localparam logic [7:0] LAT_C   = 8'(LATENCY);
    localparam logic [7:0] HDR_KEY = 8'h4B;
    localparam logic [7:0] HDR_PT  = 8'h50;

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] key_q, key_d;
    logic [127:0] pt_q, pt_d;
    logic [127:0] out_q, out_d;
    logic [7:0]   wait_q, wait_d;
    logic         tx_valid_q, tx_valid_d;
    logic         done_q, done_d;
    logic         ovr_q, ovr_d;
    logic         en_q, en_d;
    logic         busy_q, busy_d;
    logic         cnt_last_s;
`ifdef AES_CTRL_KEY_HOLD_EN
    logic         key_valid_q, key_valid_d;
`endif

    assign cnt_last_s = (cnt_q == 4'd15);

    // Next-state and datapath decisions for the frame sequencer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        pt_d    = pt_q;
        out_d   = out_q;
        wait_d  = wait_q;
        done_d  = 1'b0;
        ovr_d   = 1'b0;
`ifdef AES_CTRL_KEY_HOLD_EN
        key_valid_d = key_valid_q;
`endif
        case (state_q)
`ifdef AES_CTRL_KEY_HOLD_EN
            ST_HDR: begin
                if (rx_valid && (rx_data == HDR_KEY)) begin
                    state_d = ST_LOAD_KEY;
                    cnt_d   = 4'd0;
                end else if (rx_valid && (rx_data == HDR_PT) && key_valid_q) begin
                    state_d = ST_LOAD_PT;
                    cnt_d   = 4'd0;
                end else begin
                    state_d = ST_HDR;
                end
            end
`endif
            ST_LOAD_KEY: begin
                if (rx_valid) begin
                    key_d = {key_q[119:0], rx_data};
                    if (cnt_last_s) begin
                        cnt_d   = 4'd0;
                        state_d = ST_LOAD_PT;
`ifdef AES_CTRL_KEY_HOLD_EN
                        key_valid_d = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else begin
                    state_d = ST_LOAD_KEY;
                end
            end
            ST_LOAD_PT: begin
                if (rx_valid) begin
                    pt_d = {pt_q[119:0], rx_data};
                    if (cnt_last_s) begin
                        cnt_d   = 4'd0;
                        state_d = ST_START;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else begin
                    state_d = ST_LOAD_PT;
                end
            end
            ST_START: begin
                ovr_d   = rx_valid;
                wait_d  = 8'd1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // wait_q numbers the WAIT cycles; the last one is START+LATENCY
                ovr_d = rx_valid;
                if (wait_q == LAT_C) begin
                    out_d   = aes_cypher;
                    cnt_d   = 4'd0;
                    state_d = ST_SEND;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_SEND: begin
                ovr_d = rx_valid;
                if (tx_valid_q && tx_ready) begin
                    out_d = {out_q[119:0], 8'h00};
                    if (cnt_last_s) begin
                        cnt_d   = 4'd0;
                        done_d  = 1'b1;
                        state_d = ST_HOME;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_HOME;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Registered status outputs are decoded from the upcoming state
    always_comb begin
        en_d       = (state_d == ST_START);
        tx_valid_d = (state_d == ST_SEND);
        busy_d     = (state_d == ST_START) || (state_d == ST_WAIT) || (state_d == ST_SEND);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_HOME;
            cnt_q      <= 4'd0;
            key_q      <= 128'd0;
            pt_q       <= 128'd0;
            out_q      <= 128'd0;
            wait_q     <= 8'd0;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
`ifdef AES_CTRL_KEY_HOLD_EN
            key_valid_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            key_q      <= key_d;
            pt_q       <= pt_d;
            out_q      <= out_d;
            wait_q     <= wait_d;
            tx_valid_q <= tx_valid_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
            en_q       <= en_d;
            busy_q     <= busy_d;
`ifdef AES_CTRL_KEY_HOLD_EN
            key_valid_q <= key_valid_d;
`endif
        end
    end

    assign aes_key       = key_q;
    assign aes_plaintext = pt_q;
    assign aes_enable    = en_q;
    assign tx_data       = out_q[127:120];
    assign tx_valid      = tx_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign rx_overrun    = ovr_q;

endmodule

// File: tb/tb_aes_uart_ctrl.sv
// Scoreboard bench for aes_uart_ctrl: the bench also plays the AES core with a fixed-latency stand-in model.
`timescale 1ns/1ps
module tb_aes_uart_ctrl;
    localparam int LAT = 16;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         rx_valid = 1'b0;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready = 1'b0;
    logic [127:0] aes_key, aes_plaintext;
    logic         aes_enable;
    logic [127:0] aes_cypher = 128'd0;
    logic         busy, done, rx_overrun;

    aes_uart_ctrl #(.LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .aes_key(aes_key), .aes_plaintext(aes_plaintext), .aes_enable(aes_enable),
        .aes_cypher(aes_cypher), .busy(busy), .done(done), .rx_overrun(rx_overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0, checks = 0;
    int frames_exp = 0, ovr_exp = 0;
    int done_cnt = 0, en_cnt = 0, ovr_cnt = 0;
    int ready_mode = 0;
    logic [7:0]   exp_q[$];
    logic [255:0] exp_kp_q[$];

    // Stand-in AES core: the real vector for the FIPS-197 pair, an arbitrary mix otherwise
    function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] p);
        if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
        return {k[63:0] ^ p[127:64], k[127:64] + p[63:0]} ^ 128'h5a5a_0000_ffff_1234_0f0f_8888_abcd_0001;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Core model: result only during the START+LAT-th cycle, noise in every other cycle
    int start_cyc = -1000;
    initial forever begin
        @(negedge clk);
        if (reset && aes_enable) start_cyc = cyc;
        if (cyc == start_cyc + LAT) aes_cypher = core_fn(aes_key, aes_plaintext);
        else aes_cypher = {$urandom, $urandom, $urandom, $urandom};
    end

    int rcnt = 0;
    initial forever begin
        @(posedge clk); #1;
        case (ready_mode)
            0: tx_ready = 1'b1;
            1: begin rcnt++; tx_ready = (rcnt % 3 == 0); end
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: pops the scoreboard on every TX handshake and enable pulse
    logic       stall_prev = 1'b0;
    logic [7:0] prev_data = 8'h00;
    always @(negedge clk) begin
        if (!reset) begin
            stall_prev = 1'b0;
        end else begin
            if (aes_enable) begin
                en_cnt++;
                check("busy_in_start", busy, 1);
                if (exp_kp_q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL unexpected_enable: got pulse required none");
                end else begin
                    logic [255:0] kp;
                    kp = exp_kp_q.pop_front();
                    check("aes_key", aes_key, kp[255:128]);
                    check("aes_plaintext", aes_plaintext, kp[127:0]);
                end
            end
            if (rx_overrun) ovr_cnt++;
            if (done) begin
                done_cnt++;
                check("tx_valid_after_done", tx_valid, 0);
                check("busy_after_done", busy, 0);
            end
            if (stall_prev) begin
                check("stall_valid", tx_valid, 1);
                check("stall_data", tx_data, prev_data);
            end
            if (tx_valid && tx_ready) begin
                check("busy_in_send", busy, 1);
                if (exp_q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL unexpected_tx: got %h required none", tx_data);
                end else begin
                    check("tx_byte", tx_data, exp_q.pop_front());
                end
            end
            stall_prev = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data = b; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input logic [127:0] k, input logic [127:0] p, input int gmax);
        logic [127:0] ct;
`ifdef AES_CTRL_KEY_HOLD_EN
        send_byte(8'h4B, $urandom_range(0, gmax));
`endif
        for (int i = 0; i < 16; i++) send_byte(k[127-8*i -: 8], $urandom_range(0, gmax));
        for (int i = 0; i < 16; i++) send_byte(p[127-8*i -: 8], (i == 15) ? 0 : $urandom_range(0, gmax));
        exp_kp_q.push_back({k, p});
        ct = core_fn(k, p);
        for (int i = 0; i < 16; i++) exp_q.push_back(ct[127-8*i -: 8]);
        frames_exp++;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || done_cnt < frames_exp) && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL drain_timeout: got %0d bytes pending required 0", exp_q.size());
        end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic check_all_zero(input string name);
        check(name, {tx_data, tx_valid, aes_enable, busy, done, rx_overrun}, 0);
        check({name, "_key"}, aes_key, 0);
        check({name, "_pt"}, aes_plaintext, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

    initial begin
        #12 check_all_zero("reset_state");
        #11 reset = 1'b1;
        repeat (3) begin @(posedge clk); #1; end

`ifdef AES_CTRL_KEY_HOLD_EN
        send_byte(8'h50, 0);
        for (int i = 0; i < 16; i++) send_byte(FIPS_PT[127-8*i -: 8], 0);
        send_byte(8'h00, 0);
        repeat (40) begin @(posedge clk); #1; end
        check("no_enable_without_key", en_cnt, 0);
        send_frame(FIPS_KEY, FIPS_PT, 1);
        drain();
        send_byte(8'h50, 1);
        for (int i = 0; i < 16; i++) send_byte(FIPS_PT[127-8*i -: 8], 0);
        exp_kp_q.push_back({FIPS_KEY, FIPS_PT});
        for (int i = 0; i < 16; i++) exp_q.push_back(FIPS_CT[127-8*i -: 8]);
        frames_exp++;
        drain();
`endif

        ready_mode = 0;
        send_frame(FIPS_KEY, FIPS_PT, 0);
        drain();

        ready_mode = 1;
        send_frame(FIPS_KEY, FIPS_PT, 1);
        drain();

        ready_mode = 0;
        send_frame(FIPS_KEY, FIPS_PT, 0);
        repeat (3) begin @(posedge clk); #1; end
        for (int i = 0; i < 3; i++) send_byte(8'hA0 + 8'(i), 1);
        ovr_exp += 3;
        drain();

`ifdef AES_CTRL_KEY_HOLD_EN
        send_byte(8'h4B, 0);
`endif
        for (int i = 0; i < 16; i++) send_byte(FIPS_KEY[127-8*i -: 8], 0);
        for (int i = 0; i < 5; i++) send_byte(FIPS_PT[127-8*i -: 8], 0);
        reset = 1'b0;
        #2 check_all_zero("reset_mid_frame");
        @(negedge clk) check_all_zero("reset_held");
        @(posedge clk); #3 reset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        send_frame(FIPS_KEY, FIPS_PT, 0);
        drain();

        for (int f = 0; f < 6; f++) begin
            ready_mode = $urandom_range(0, 2);
            send_frame({$urandom, $urandom, $urandom, $urandom},
                       {$urandom, $urandom, $urandom, $urandom}, 2);
            drain();
        end

        repeat (20) begin @(posedge clk); #1; end
        check("done_count", done_cnt, frames_exp);
        check("enable_count", en_cnt, frames_exp);
        check("overrun_count", ovr_cnt, ovr_exp);
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/aes_uart_ctrl.md
AES_UART_CTRL -- requirements
Module: aes_uart_ctrl

Interface
REQ-001 SHALL have parameter: LATENCY, default 16, cycles from aes_enable pulse to valid aes_cypher (legal 1..255).
REQ-002 SHALL have port: clk  in  1  single clock, all logic on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: rx_data  in  8  received UART byte.
REQ-005 SHALL have port: rx_valid  in  1  one-cycle strobe, rx_data valid.
REQ-006 SHALL have port: tx_data  out  8  cipher byte to UART TX.
REQ-007 SHALL have port: tx_valid  out  1  tx_data valid.
REQ-008 SHALL have port: tx_ready  in  1  UART TX accepts byte.
REQ-009 SHALL have port: aes_key  out  128  key to AES_Encryption core.
REQ-010 SHALL have port: aes_plaintext  out  128  plaintext to core.
REQ-011 SHALL have port: aes_enable  out  1  one-cycle start pulse to core.
REQ-012 SHALL have port: aes_cypher  in  128  core result.
REQ-013 SHALL have port: busy  out  1  high in START, WAIT, SEND.
REQ-014 SHALL have port: done  out  1  one-cycle pulse after last cipher byte accepted.
REQ-015 SHALL have port: rx_overrun  out  1  one-cycle pulse per dropped rx byte.

Function
REQ-016 SHALL implement states LOAD_KEY, LOAD_PT, START, WAIT, SEND (plus HDR per REQ-031); home state = LOAD_KEY without macro, HDR with it.
REQ-017 LOAD_KEY SHALL shift each rx_valid byte in as aes_key <= {aes_key[119:0], rx_data}; first byte ends in [127:120]; 16th byte -> LOAD_PT, byte count cleared.
REQ-018 LOAD_PT SHALL shift aes_plaintext identically; 16th byte -> START.
REQ-019 START SHALL last exactly one cycle with aes_enable=1, then -> WAIT; aes_enable SHALL be 0 in every other state.
REQ-020 WAIT SHALL count LATENCY cycles from the START cycle; on the clock edge ending the START+LATENCY-th cycle, aes_cypher SHALL be captured into an internal 128-bit output register and state -> SEND.
REQ-021 aes_key and aes_plaintext SHALL be held stable in START, WAIT, SEND.
REQ-022 SEND SHALL drive tx_valid=1, tx_data = output register [127:120]; on tx_valid&&tx_ready shift register left 8 and increment byte count.
REQ-023 While tx_valid && !tx_ready, tx_data SHALL remain stable; tx_valid SHALL not drop before handshake.
REQ-024 After the 16th handshake: tx_valid=0 next cycle, done=1 for exactly one cycle, state -> home state.
REQ-025 rx_valid in START, WAIT or SEND SHALL drop the byte and pulse rx_overrun the following cycle; loaded data and count unaffected.
REQ-026 rx_valid coincident with the 16th-byte transition SHALL be consumed by the current state only; no byte is counted twice.
REQ-027 Byte counters SHALL be 4-bit plus terminal detection; no wrap beyond 16 in any state.

Reset
REQ-028 reset low SHALL immediately force home state, counters 0, aes_key, aes_plaintext, output register 0, all 1-bit outputs 0, tx_data 0, key_valid 0.
REQ-029 Reset asserted mid-frame or mid-SEND SHALL abort the frame; no done pulse; next complete frame SHALL process normally.
REQ-030 Release SHALL be synchronised so the first rising edge after deassertion is a normal edge in home state.

Configuration
REQ-031 Macro AES_CTRL_KEY_HOLD_EN defined: HDR state first; header 0x4B ('K') -> LOAD_KEY; 0x50 ('P') -> LOAD_PT reusing aes_key if key_valid=1, else byte discarded, stay HDR; any other header discarded, stay HDR; key_valid set on 16th key byte.
REQ-032 Macro undefined: no HDR state, no key_valid flag; every frame is exactly 16 key bytes then 16 plaintext bytes.

Verification
REQ-033 Frame key 000102..0f then pt 00112233..ff, tx_ready=1 -> one aes_enable pulse, tx bytes 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a, one done pulse.
REQ-034 Same frame, tx_ready toggling 1-of-3 cycles -> tx_data stable while stalled, same 16 bytes in order.
REQ-035 3 rx bytes injected during WAIT -> 3 rx_overrun pulses, cipher output unchanged from REQ-033.
REQ-036 reset low after 5 plaintext bytes -> all outputs 0, no done; subsequent full frame yields REQ-033 result.
REQ-037 With AES_CTRL_KEY_HOLD_EN: 'P'+16 bytes before any key -> no aes_enable; 0x00 header ignored; 'K' frame then 'P' frame with same plaintext -> identical cipher 69c4...c55a twice.
